// File: rtl/spi_sb_sequencer_if.sv
// System-bus connection between the SPI sequencer (master) and the SPI IP
// register file (slave): one access at a time, strobe held until acknowledge.
interface spi_sb_sequencer_if;
  logic [7:0] sb_adr_o;
  logic [7:0] sb_dat_o;
  logic       sb_we_o;
  logic       sb_stb_o;
  logic [7:0] sb_dat_i;
  logic       sb_ack_i;

  modport master (
    output sb_adr_o, sb_dat_o, sb_we_o, sb_stb_o,
    input  sb_dat_i, sb_ack_i
  );

  modport slave (
    input  sb_adr_o, sb_dat_o, sb_we_o, sb_stb_o,
    output sb_dat_i, sb_ack_i
  );
endinterface

// File: rtl/spi_sb_sequencer.sv
// Register-level sequencer for an SPI master IP on the system bus. It writes
// the configuration registers on request, and for a transfer asserts chip
// select, then per byte polls TRDY, writes TXDR, polls RRDY, reads RXDR and
// hands the byte out, finally releasing chip select. Status errors or a poll
// timeout release chip select and finish with err instead of done.
module spi_sb_sequencer #(
  parameter logic [3:0] SB_ID    = 4'b0001,
  parameter int         POLL_MAX = 255
) (
  input  logic                      sb_clk_i,
  input  logic                      spi_rst,
  spi_sb_sequencer_if.master        sb,
  input  logic                      cfg_req,
  input  logic [31:0]               cfg_data,
  input  logic                      xfer_req,
  input  logic [3:0]                xfer_len,
  input  logic [7:0]                xfer_csr,
  input  logic [7:0]                tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [7:0]                rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  // Poll counter holds 0..POLL_MAX-1; reaching the last value on a miss is a timeout.
  localparam int PW = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  localparam logic [3:0] OFS_CR0  = 4'h8;
  localparam logic [3:0] OFS_SR   = 4'hC;
  localparam logic [3:0] OFS_TXDR = 4'hD;
  localparam logic [3:0] OFS_RXDR = 4'hE;
  localparam logic [3:0] OFS_CSR  = 4'hF;

  localparam int SR_TRDY = 4;
  localparam int SR_RRDY = 3;
  localparam int SR_TOE  = 2;
  localparam int SR_ROE  = 1;
  localparam int SR_MDF  = 0;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CFG, ST_CS_ON, ST_POLL_T, ST_WR_TX,
    ST_POLL_R, ST_RD_RX, ST_RX_OUT, ST_CS_OFF, ST_FIN
  } state_t;

  state_t        state_q, state_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [7:0]    adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;
  logic          gap_q, gap_d;
  logic [31:0]   cfg_q, cfg_d;
  logic [7:0]    csr_q, csr_d;
  logic [4:0]    rem_q, rem_d;
  logic [1:0]    idx_q, idx_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          fail_q, fail_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          bus_free;
  logic          ack;
  logic          acc_go;
  logic [3:0]    acc_ofs;
  logic [7:0]    acc_dat;
  logic          acc_we;

  function automatic logic sr_fault(input logic [7:0] sr);
    return sr[SR_TOE] | sr[SR_ROE] | sr[SR_MDF];
  endfunction

  // cfg_data is packed {CR0,CR1,CR2,BR}; idx 0 selects CR0.
  function automatic logic [7:0] cfg_byte(input logic [31:0] cfg, input logic [1:0] idx);
    case (idx)
      2'd0:    return cfg[31:24];
      2'd1:    return cfg[23:16];
      2'd2:    return cfg[15:8];
      default: return cfg[7:0];
    endcase
  endfunction

  // Next-state logic: sequence FSM plus the single-outstanding bus access engine.
  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    gap_d      = 1'b0;
    cfg_d      = cfg_q;
    csr_d      = csr_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    poll_d     = poll_q;
    fail_d     = fail_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tx_ready   = 1'b0;
    acc_go     = 1'b0;
    acc_ofs    = 4'h0;
    acc_dat    = 8'h00;
    acc_we     = 1'b0;

    // A new access may start only when strobe is low and the mandatory idle
    // cycle after the previous acknowledge has passed.
    bus_free = !stb_q && !gap_q;
    ack      = stb_q && sb.sb_ack_i;
    if (ack) begin
      stb_d = 1'b0;
      gap_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_req) begin
          cfg_d   = cfg_data;
          idx_d   = 2'd0;
          fail_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_CFG;
        end else if (xfer_req) begin
          csr_d   = xfer_csr;
          rem_d   = {1'b0, xfer_len} + 5'd1;
          fail_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_CS_ON;
        end
      end
      ST_CFG: begin
        acc_go  = bus_free;
        acc_ofs = OFS_CR0 + {2'b00, idx_q};
        acc_dat = cfg_byte(cfg_q, idx_q);
        acc_we  = 1'b1;
        if (ack) begin
          if (idx_q == 2'd3) state_d = ST_FIN;
          else               idx_d   = idx_q + 2'd1;
        end
      end
      ST_CS_ON: begin
        acc_go  = bus_free;
        acc_ofs = OFS_CSR;
        acc_dat = csr_q;
        acc_we  = 1'b1;
        if (ack) begin
          poll_d  = '0;
          state_d = ST_POLL_T;
        end
      end
      ST_POLL_T: begin
        acc_go  = bus_free;
        acc_ofs = OFS_SR;
        if (ack) begin
          if (sr_fault(sb.sb_dat_i)) begin
            fail_d  = 1'b1;
            state_d = ST_CS_OFF;
          end else if (sb.sb_dat_i[SR_TRDY]) begin
            state_d = ST_WR_TX;
          end else if (poll_q == POLL_LAST) begin
            fail_d  = 1'b1;
            state_d = ST_CS_OFF;
          end else begin
            poll_d = poll_q + PW'(1);
          end
        end
      end
      ST_WR_TX: begin
        // Ready is raised only in the cycle the byte is taken onto the bus.
        tx_ready = bus_free && tx_valid;
        acc_go   = bus_free && tx_valid;
        acc_ofs  = OFS_TXDR;
        acc_dat  = tx_data;
        acc_we   = 1'b1;
        if (ack) begin
          poll_d  = '0;
          state_d = ST_POLL_R;
        end
      end
      ST_POLL_R: begin
        acc_go  = bus_free;
        acc_ofs = OFS_SR;
        if (ack) begin
          if (sr_fault(sb.sb_dat_i)) begin
            fail_d  = 1'b1;
            state_d = ST_CS_OFF;
          end else if (sb.sb_dat_i[SR_RRDY]) begin
            state_d = ST_RD_RX;
          end else if (poll_q == POLL_LAST) begin
            fail_d  = 1'b1;
            state_d = ST_CS_OFF;
          end else begin
            poll_d = poll_q + PW'(1);
          end
        end
      end
      ST_RD_RX: begin
        acc_go  = bus_free;
        acc_ofs = OFS_RXDR;
        if (ack) begin
          rx_data_d  = sb.sb_dat_i;
          rx_valid_d = 1'b1;
          state_d    = ST_RX_OUT;
        end
      end
      ST_RX_OUT: begin
        if (rx_valid_q && rx_ready) begin
          rx_valid_d = 1'b0;
          rem_d      = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            state_d = ST_CS_OFF;
          end else begin
            poll_d  = '0;
            state_d = ST_POLL_T;
          end
        end
      end
      ST_CS_OFF: begin
        acc_go  = bus_free;
        acc_ofs = OFS_CSR;
        acc_dat = 8'h00;
        acc_we  = 1'b1;
        if (ack) state_d = ST_FIN;
      end
      ST_FIN: begin
        done_d  = !fail_q;
        err_d   = fail_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (acc_go) begin
      stb_d = 1'b1;
      adr_d = {SB_ID, acc_ofs};
      dat_d = acc_dat;
      we_d  = acc_we;
    end
  end

  // State register; reset drops any access in flight without another bus cycle.
  always_ff @(posedge sb_clk_i) begin
    if (spi_rst) begin
      state_q    <= ST_IDLE;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 8'h00;
      dat_q      <= 8'h00;
      gap_q      <= 1'b0;
      cfg_q      <= 32'h0;
      csr_q      <= 8'h00;
      rem_q      <= 5'd0;
      idx_q      <= 2'd0;
      poll_q     <= '0;
      fail_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      gap_q      <= gap_d;
      cfg_q      <= cfg_d;
      csr_q      <= csr_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      poll_q     <= poll_d;
      fail_q     <= fail_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign sb.sb_adr_o = adr_q;
  assign sb.sb_dat_o = dat_q;
  assign sb.sb_we_o  = we_q;
  assign sb.sb_stb_o = stb_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_spi_sb_sequencer.sv
// Bench for spi_sb_sequencer: a bus slave model answers register accesses and
// checks them against a queue of expected accesses, a TX source and an RX sink
// drive the byte streams, and directed steps cover configuration, transfers,
// poll timeout, status errors and reset during a held strobe.
module tb_spi_sb_sequencer;

  typedef struct packed {
    logic       we;
    logic [7:0] adr;
    logic [7:0] dat;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_req, xfer_req;
  logic [31:0] cfg_data;
  logic [3:0]  xfer_len;
  logic [7:0]  xfer_csr;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic        busy, done, err;

  spi_sb_sequencer_if bus ();

  spi_sb_sequencer #(.SB_ID(4'b0001), .POLL_MAX(4)) dut (
    .sb_clk_i (clk),
    .spi_rst  (rst),
    .sb       (bus),
    .cfg_req  (cfg_req),
    .cfg_data (cfg_data),
    .xfer_req (xfer_req),
    .xfer_len (xfer_len),
    .xfer_csr (xfer_csr),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;

  acc_t       exp_bus[$];
  logic [7:0] exp_rx[$];
  logic [7:0] sr_q[$];
  logic [7:0] rxdr_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] sr_default = 8'h18;
  int         ack_dly_max = 0;
  int         ack_budget = -1;
  int         stall_byte = -1;
  int         stall_len = 0;
  int         stall_seen = 0;
  int         rx_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_acc(input logic we, input logic [7:0] adr, input logic [7:0] dat);
    acc_t a;
    a.we = we; a.adr = adr; a.dat = dat;
    exp_bus.push_back(a);
  endtask

  task automatic pulse_req(input logic c, input logic x);
    cfg_req = c; xfer_req = x;
    cyc(1);
    cfg_req = 1'b0; xfer_req = 1'b0;
  endtask

  task automatic finish_seq(input string tag, input logic exp_done);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (done || err) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_end"}, 32'(seen), 1);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_err"}, 32'(err), 32'(!exp_done));
    @(negedge clk);
    check({tag, "_pulse"}, {done, err, busy}, 3'b000);
    check({tag, "_bus_left"}, exp_bus.size(), 0);
    check({tag, "_rx_left"}, exp_rx.size(), 0);
  endtask

  // Bus slave: acks after a random delay, supplies SR/RXDR data, checks accesses.
  initial begin : slave
    int   wait_n = 0;
    int   low_chk = 0;
    bit   in_acc = 1'b0;
    acc_t snap, e;
    logic [7:0] rd;
    bus.sb_ack_i = 1'b0;
    bus.sb_dat_i = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.sb_ack_i = 1'b0; bus.sb_dat_i = 8'h00; in_acc = 1'b0; low_chk = 0;
        continue;
      end
      if (bus.sb_ack_i) begin
        bus.sb_ack_i = 1'b0; bus.sb_dat_i = 8'h00; low_chk = 2;
      end
      if (low_chk > 0) begin
        check("stb_idle_after_ack", 32'(bus.sb_stb_o), 0);
        low_chk--;
      end else if (bus.sb_stb_o) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          snap = {bus.sb_we_o, bus.sb_adr_o, bus.sb_dat_o};
          wait_n = $urandom_range(0, ack_dly_max);
        end else begin
          check("stb_hold_stable", {bus.sb_we_o, bus.sb_adr_o, bus.sb_dat_o}, snap);
        end
        if (ack_budget != 0 && wait_n == 0) begin
          rd = 8'h00;
          if (!bus.sb_we_o && bus.sb_adr_o == 8'h1C)
            rd = (sr_q.size() > 0) ? sr_q.pop_front() : sr_default;
          else if (!bus.sb_we_o && bus.sb_adr_o == 8'h1E)
            rd = (rxdr_q.size() > 0) ? rxdr_q.pop_front() : 8'hEE;
          bus.sb_dat_i = rd;
          bus.sb_ack_i = 1'b1;
          in_acc = 1'b0;
          if (ack_budget > 0) ack_budget--;
          check("bus_pending", 32'(exp_bus.size() > 0), 1);
          if (exp_bus.size() > 0) begin
            e = exp_bus.pop_front();
            check("bus_access",
                  {bus.sb_we_o, bus.sb_adr_o, bus.sb_we_o ? bus.sb_dat_o : 8'h00},
                  {e.we, e.adr, e.we ? e.dat : 8'h00});
          end
        end else if (wait_n > 0) begin
          wait_n--;
        end
      end
    end
  end

  // TX source: presents the head of tx_q; a byte leaves the queue once taken.
  initial begin : tx_src
    bit acc = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (acc) begin
        void'(tx_q.pop_front());
        acc = 1'b0;
      end
      if (tx_q.size() > 0) begin
        tx_valid = 1'b1; tx_data = tx_q[0];
      end else begin
        tx_valid = 1'b0; tx_data = 8'h00;
      end
      #1;
      if (tx_valid && tx_ready && !rst) acc = 1'b1;
    end
  end

  // RX sink: optionally stalls one byte, checks stability and byte order.
  initial begin : rx_sink
    bit         seen = 1'b0;
    int         stall_left = 0;
    logic [7:0] hold = 8'h00;
    rx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_ready = 1'b0; seen = 1'b0;
        continue;
      end
      if (rx_valid) begin
        if (!seen) begin
          seen = 1'b1;
          hold = rx_data;
          stall_left = (rx_idx == stall_byte) ? stall_len : 0;
        end else begin
          check("rx_stable", 32'(rx_data), 32'(hold));
        end
        if (stall_left > 0) begin
          rx_ready = 1'b0;
          stall_left--;
          stall_seen++;
        end else begin
          rx_ready = 1'b1;
          check("rx_pending", 32'(exp_rx.size() > 0), 1);
          if (exp_rx.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
          rx_idx++;
          seen = 1'b0;
        end
      end else begin
        if (seen) check("rx_valid_hold", 32'(rx_valid), 1);
        seen = 1'b0;
        rx_ready = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst = 1'b1; cfg_req = 1'b0; xfer_req = 1'b0;
    cfg_data = 32'h0; xfer_len = 4'h0; xfer_csr = 8'h00;
    cyc(3);
    check("rst_ctrl", {bus.sb_stb_o, bus.sb_we_o, tx_ready, rx_valid, busy, done, err}, 0);
    check("rst_bus", {bus.sb_adr_o, bus.sb_dat_o}, 0);
    check("rst_rx_data", 32'(rx_data), 0);
    rst = 1'b0;
    cyc(2);

    // Configuration writes
    ack_dly_max = 2;
    push_acc(1, 8'h18, 8'h80); push_acc(1, 8'h19, 8'hC3);
    push_acc(1, 8'h1A, 8'h04); push_acc(1, 8'h1B, 8'h07);
    cfg_data = 32'h80_C3_04_07;
    pulse_req(1, 0);
    check("cfg_busy", 32'(busy), 1);
    finish_seq("cfg", 1);

    // Single-byte transfer; a cfg_req while busy must be ignored
    sr_q = '{8'h10, 8'h08}; rxdr_q = '{8'h3C}; tx_q = '{8'hA5}; exp_rx = '{8'h3C};
    push_acc(1, 8'h1F, 8'hFE); push_acc(0, 8'h1C, 8'h00); push_acc(1, 8'h1D, 8'hA5);
    push_acc(0, 8'h1C, 8'h00); push_acc(0, 8'h1E, 8'h00); push_acc(1, 8'h1F, 8'h00);
    xfer_len = 4'd0; xfer_csr = 8'hFE; rx_idx = 0;
    pulse_req(0, 1);
    check("xfer1_busy", 32'(busy), 1);
    cyc(4);
    cfg_data = 32'hDEAD_BEEF;
    pulse_req(1, 0);
    finish_seq("xfer1", 1);

    // 16-byte transfer with a 10-cycle RX stall on byte 3
    push_acc(1, 8'h1F, 8'h7E);
    for (int i = 0; i < 16; i++) begin
      tx_q.push_back(8'(8'h40 + 3 * i));
      rxdr_q.push_back(8'(8'h05 + 8'h11 * i));
      exp_rx.push_back(8'(8'h05 + 8'h11 * i));
      push_acc(0, 8'h1C, 8'h00);
      push_acc(1, 8'h1D, 8'(8'h40 + 3 * i));
      push_acc(0, 8'h1C, 8'h00);
      push_acc(0, 8'h1E, 8'h00);
    end
    push_acc(1, 8'h1F, 8'h00);
    xfer_len = 4'd15; xfer_csr = 8'h7E; rx_idx = 0;
    stall_byte = 3; stall_len = 10; stall_seen = 0;
    pulse_req(0, 1);
    finish_seq("xfer16", 1);
    check("xfer16_stall_cycles", stall_seen, 10);
    check("xfer16_bytes", rx_idx, 16);
    stall_byte = -1;

    // Two bytes; first TRDY arrives on the last permitted poll read
    sr_q = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h08};
    tx_q = '{8'hA1, 8'hA2}; rxdr_q = '{8'h51, 8'h52}; exp_rx = '{8'h51, 8'h52};
    push_acc(1, 8'h1F, 8'hBD);
    for (int i = 0; i < 4; i++) push_acc(0, 8'h1C, 8'h00);
    push_acc(1, 8'h1D, 8'hA1); push_acc(0, 8'h1C, 8'h00); push_acc(0, 8'h1E, 8'h00);
    push_acc(0, 8'h1C, 8'h00); push_acc(1, 8'h1D, 8'hA2); push_acc(0, 8'h1C, 8'h00);
    push_acc(0, 8'h1E, 8'h00); push_acc(1, 8'h1F, 8'h00);
    xfer_len = 4'd1; xfer_csr = 8'hBD; rx_idx = 0;
    pulse_req(0, 1);
    finish_seq("poll_edge", 1);

    // SR stuck at 00: exactly POLL_MAX reads then error exit
    sr_default = 8'h00;
    push_acc(1, 8'h1F, 8'hEF);
    for (int i = 0; i < 4; i++) push_acc(0, 8'h1C, 8'h00);
    push_acc(1, 8'h1F, 8'h00);
    xfer_len = 4'd0; xfer_csr = 8'hEF;
    pulse_req(0, 1);
    finish_seq("poll_timeout", 0);
    sr_default = 8'h18;

    // TRDY together with TOE: error wins, no TXDR write
    sr_q = '{8'h14};
    push_acc(1, 8'h1F, 8'hEF); push_acc(0, 8'h1C, 8'h00); push_acc(1, 8'h1F, 8'h00);
    pulse_req(0, 1);
    finish_seq("sr_toe", 0);

    // ROE seen while waiting for RRDY
    sr_q = '{8'h10, 8'h02}; tx_q = '{8'h77};
    push_acc(1, 8'h1F, 8'hEF); push_acc(0, 8'h1C, 8'h00); push_acc(1, 8'h1D, 8'h77);
    push_acc(0, 8'h1C, 8'h00); push_acc(1, 8'h1F, 8'h00);
    pulse_req(0, 1);
    finish_seq("sr_roe", 0);

    // Simultaneous requests, then reset while the second CR write is unacknowledged
    begin
      bit seen = 1'b0;
      ack_budget = 1;
      push_acc(1, 8'h18, 8'h80);
      cfg_data = 32'h80_C3_04_07; xfer_csr = 8'hFE; xfer_len = 4'd0;
      pulse_req(1, 1);
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (ack_budget == 0 && bus.sb_stb_o) seen = 1'b1;
      end
      check("rst_reach_hold", 32'(seen), 1);
      cyc(3);
      check("rst_held_stb", 32'(bus.sb_stb_o), 1);
      check("rst_cfg_priority", 32'(bus.sb_adr_o), 32'h19);
      rst = 1'b1;
      cyc(1);
      check("rst_mid_ctrl", {bus.sb_stb_o, bus.sb_we_o, tx_ready, rx_valid, busy, done, err}, 0);
      check("rst_mid_bus", {bus.sb_adr_o, bus.sb_dat_o}, 0);
      check("rst_mid_rx_data", 32'(rx_data), 0);
      cyc(1);
      rst = 1'b0;
      ack_budget = -1;
      cyc(6);
      check("rst_quiet", {bus.sb_stb_o, busy, done, err}, 0);
      check("rst_bus_left", exp_bus.size(), 0);
    end

    // Fresh configuration after reset proves the sequencer is idle again
    push_acc(1, 8'h18, 8'h01); push_acc(1, 8'h19, 8'h02);
    push_acc(1, 8'h1A, 8'h03); push_acc(1, 8'h1B, 8'h04);
    cfg_data = 32'h01_02_03_04;
    pulse_req(1, 0);
    finish_seq("cfg_after_rst", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
